mul64_seq_ctrl: RTL

//  Iterative radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU.

---
 rtl/mul64_seq_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mul64_seq_ctrl.sv
// Iterative radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU, one adder64b, 64 iterations.
// Optional feature: define MUL_ZERO_BYPASS_EN to short-circuit zero operands straight to a zero result.

module adder64b (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        sub,
  output logic [63:0] s,
  output logic        c_o
);
  logic [64:0] sum;

  assign sum = {1'b0, a} + {1'b0, b ^ {64{sub}}} + {64'd0, sub};
  assign s   = sum[63:0];
  assign c_o = sum[64];
endmodule

module mul64_seq_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULH = 2'b01, OP_MULHSU = 2'b10, OP_MULHU = 2'b11} op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d, op_in;
  logic [XLEN-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d, out_valid_q, out_valid_d;
`ifdef MUL_ZERO_BYPASS_EN
  logic              zero_q, zero_d;
`endif

  logic [XLEN-1:0]   add_a, add_b, add_s;
  logic              add_sub, add_c;
  logic              rs1_sgn, rs2_sgn, neg_in;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;

  adder64b u_add (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .s   (add_s),
    .c_o (add_c)
  );

  assign op_in   = op_e'(op);
  assign rs1_sgn = (op_in == OP_MULH) || (op_in == OP_MULHSU);
  assign rs2_sgn = (op_in == OP_MULH);
  assign rs1_mag = (rs1_sgn && rs1[XLEN-1]) ? (~rs1 + XLEN'(1)) : rs1;
  assign rs2_mag = (rs2_sgn && rs2[XLEN-1]) ? (~rs2 + XLEN'(1)) : rs2;
  assign neg_in  = (op_in == OP_MULH)   ? (rs1[XLEN-1] ^ rs2[XLEN-1]) :
                   (op_in == OP_MULHSU) ? rs1[XLEN-1] : 1'b0;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    m_d         = m_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
`ifdef MUL_ZERO_BYPASS_EN
    zero_d      = zero_q;
`endif
    add_a       = '0;
    add_b       = '0;
    add_sub     = 1'b0;

    if (kill) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d    = op_in;
            m_d     = rs1_mag;
            lo_d    = rs2_mag;
            hi_d    = '0;
            cnt_d   = '0;
            neg_d   = neg_in;
            state_d = S_RUN;
`ifdef MUL_ZERO_BYPASS_EN
            zero_d  = (rs1 == '0) || (rs2 == '0);
`endif
          end
        end
        S_RUN: begin
          add_a = hi_q;
          add_b = m_q;
          if (lo_q[0]) begin
            {hi_d, lo_d} = {add_c, add_s, lo_q[XLEN-1:1]};
          end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
`ifdef MUL_ZERO_BYPASS_EN
          // A zero operand spends exactly one cycle here and bypasses the iterations.
          if (zero_q) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = '0;
          end else
`endif
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            if (neg_q && (op_q != OP_MUL)) begin
              state_d = S_FIX;
            end else begin
              state_d     = S_DONE;
              out_valid_d = 1'b1;
              result_d    = (op_q == OP_MUL) ? lo_d : hi_d;
            end
          end
        end
        S_FIX: begin
          // Two's-complement of {hi,lo}: the +1 only reaches hi when lo is zero.
          add_b       = hi_q;
          add_sub     = 1'b1;
          hi_d        = (lo_q == '0) ? add_s : ~hi_q;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = hi_d;
        end
        S_DONE: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MUL;
      m_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef MUL_ZERO_BYPASS_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      m_q         <= m_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
`ifdef MUL_ZERO_BYPASS_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
endmodule
